mem_stage_ext: RTL and testbench
================================

MEM_STAGE_EXT -- requirements
Module: mem_stage_ext

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the datapath width in bits; legal values are 32 only, and an illegal value SHALL be an elaboration error.
REQ-002 Parameter DEPTH_LOG2, default 10, SHALL set data memory depth to 2**DEPTH_LOG2 words.
REQ-003 Parameter MEM_LATENCY, default 0, SHALL set the number of wait states per memory access; legal range is 0..7.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  instruction present in the MEM stage this cycle.
REQ-007 address  in  DATA_W  ALU result and byte address.
REQ-008 write_data  in  DATA_W  store data, right-aligned.
REQ-009 write_reg  in  5  destination register.
REQ-010 memwrite, memread  in  1 each  store and load strobes.
REQ-011 size  in  2  access size: 00 byte, 01 half, 10 word; 11 is reserved.
REQ-012 sign_ext  in  1  sign-extend a sub-word load.
REQ-013 branch, branch_ne  in  1 each  branch instruction; branch_ne=1 selects bne semantics.
REQ-014 zero  in  1  ALU zero flag.
REQ-015 control_wb  in  2  write-back control.
REQ-016 stall  out  1  freezes upstream stages and PC.
REQ-017 PCSrc  out  1  branch taken.
REQ-018 mem_valid  out  1  registered valid for the WB stage.
REQ-019 mem_control_wb  out  2  registered control_wb.
REQ-020 mem_read_data  out  DATA_W  registered, aligned and extended load data.
REQ-021 mem_ALU_result  out  DATA_W  registered address.
REQ-022 mem_Write_reg  out  5  registered write_reg.
REQ-023 mem_misalign  out  1  registered misalignment flag for the latched instruction.

Function
REQ-024 An access SHALL be accepted in cycle T when in_valid=1 and (memread|memwrite)=1.
REQ-025 The FSM SHALL use two states, IDLE and WAIT. An access accepted in IDLE with MEM_LATENCY>0 SHALL move the FSM to WAIT and load the wait counter with MEM_LATENCY-1. In WAIT, the counter SHALL decrement each cycle, and the FSM SHALL return to IDLE in the cycle after the counter reads 0.
REQ-026 stall SHALL be combinationally high in cycles T..T+MEM_LATENCY-1 and low in cycle T+MEM_LATENCY; with MEM_LATENCY=0, stall SHALL never assert.
REQ-027 Upstream SHALL hold all inputs stable while stall=1; the block SHALL NOT sample new instructions during stall.
REQ-028 The MEM/WB latch SHALL capture only at the rising edge ending a cycle where stall=0.
REQ-029 The store SHALL commit at that same edge, with byte enables derived from size and address[1:0] (little-endian); write_data bits are routed to the selected lanes.
REQ-030 A load SHALL select bytes by address[1:0]. Sub-word results SHALL be zero-extended, or sign-extended when sign_ext=1, to DATA_W.
REQ-031 Word index SHALL be address[DEPTH_LOG2+1:2]; higher address bits SHALL be ignored, so addresses wrap.
REQ-032 Misalignment SHALL be half with address[0]=1, word with address[1:0]!=0, or size=11. A misaligned access SHALL perform no write, latch mem_read_data=0 and mem_misalign=1, and incur no wait states.
REQ-033 PCSrc SHALL equal in_valid & branch & (zero ^ branch_ne), combinationally, and SHALL remain valid through stall cycles.
REQ-034 A non-memory instruction SHALL pass with 0 wait states, mem_read_data=0.
REQ-035 When in_valid=0, the latch SHALL capture a bubble: mem_valid=0, mem_control_wb=0, and all other latch outputs 0.
REQ-036 If memread and memwrite are both 1, the store SHALL take effect and mem_read_data SHALL return the pre-write contents.

Reset
REQ-037 While reset=1 at a rising edge, the FSM SHALL go to IDLE, the counter SHALL clear to 0, and all mem_* outputs SHALL clear to 0.
REQ-038 Reset during WAIT SHALL abort the access, with no memory write; stall SHALL be 0 in the first cycle after reset.
REQ-039 Memory contents SHALL NOT be reset.

Structure
REQ-040 Package mem_stage_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state enum, and the lane-enable function.
REQ-041 One sub-module, byte_lane_mem, SHALL implement the DATA_W/8-lane memory with a synchronous write, per-lane enables, and an asynchronous read.

Verification
REQ-042 Scenario: MEM_LATENCY=0; sw 0xDEADBEEF @0x10, then lw @0x10 -> mem_read_data=0xDEADBEEF one cycle later, with stall never high.
REQ-043 Scenario: MEM_LATENCY=3; lw accepted at T -> stall high for T..T+2, latched at the end of T+3, and the next instruction sampled at T+4.
REQ-044 Scenario: word 0x80FF7F01 @0x20; lb @0x22 sign_ext=1 -> 0xFFFFFFFF, lbu @0x23 -> 0x00000080, lh @0x22 -> 0xFFFF80FF.
REQ-045 Scenario: sh @0x21 -> mem_misalign=1, memory unchanged, mem_read_data=0, no stall.
REQ-046 Scenario: branch=1, branch_ne=1, zero=0 -> PCSrc=1; with zero=1 -> PCSrc=0; and PCSrc held constant across a 3-cycle stall.
REQ-047 Scenario: reset asserted in the second WAIT cycle of a sw -> target word unchanged, all mem_* outputs 0, stall 0 next cycle.

Source files
------------

// File: rtl/mem_stage_ext_pkg.sv
// mem_stage_pkg: shared size encodings, FSM states and lane helpers for the MEM stage
package mem_stage_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic {IDLE, WAIT} state_t;

    // Little-endian byte enables for a 32-bit word; reserved size enables nothing
    function automatic logic [3:0] lane_en(input logic [1:0] size, input logic [1:0] lo);
        return size == SZ_BYTE ? 4'b0001 << lo :
               size == SZ_HALF ? 4'b0011 << lo :
               size == SZ_WORD ? 4'b1111 : 4'b0000;
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        return size == SZ_RSVD || (size == SZ_HALF && lo[0]) || (size == SZ_WORD && lo != 2'b00);
    endfunction
endpackage

// File: rtl/mem_stage_ext_if.sv
// mem_stage_ext_if: EX/MEM inputs, stall/branch outputs and MEM/WB latch outputs
interface mem_stage_ext_if #(parameter int DATA_W = 32);
    logic              in_valid;
    logic [DATA_W-1:0] address;
    logic [DATA_W-1:0] write_data;
    logic [4:0]        write_reg;
    logic              memwrite;
    logic              memread;
    logic [1:0]        size;
    logic              sign_ext;
    logic              branch;
    logic              branch_ne;
    logic              zero;
    logic [1:0]        control_wb;
    logic              stall;
    logic              PCSrc;
    logic              mem_valid;
    logic [1:0]        mem_control_wb;
    logic [DATA_W-1:0] mem_read_data;
    logic [DATA_W-1:0] mem_ALU_result;
    logic [4:0]        mem_Write_reg;
    logic              mem_misalign;

    modport master (
        output in_valid, address, write_data, write_reg, memwrite, memread, size, sign_ext,
               branch, branch_ne, zero, control_wb,
        input  stall, PCSrc, mem_valid, mem_control_wb, mem_read_data, mem_ALU_result,
               mem_Write_reg, mem_misalign
    );

    modport slave (
        input  in_valid, address, write_data, write_reg, memwrite, memread, size, sign_ext,
               branch, branch_ne, zero, control_wb,
        output stall, PCSrc, mem_valid, mem_control_wb, mem_read_data, mem_ALU_result,
               mem_Write_reg, mem_misalign
    );
endinterface

// File: rtl/mem_stage_ext_byte_lane_mem.sv
// byte_lane_mem: word-addressed memory with per-byte-lane synchronous write and async read
module byte_lane_mem #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);
    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

    // Each enabled lane takes its byte of wdata; contents are never reset
    always_ff @(posedge clk)
        for (int i = 0; i < DATA_W/8; i++)
            if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];

    assign rdata = mem[addr];
endmodule

// File: rtl/mem_stage_ext.sv
// mem_stage_ext: pipeline MEM stage with wait-state FSM, sub-word load/store and MEM/WB latch
module mem_stage_ext
    import mem_stage_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH_LOG2  = 10,
    parameter int MEM_LATENCY = 0
) (
    input logic            clk,
    input logic            reset,
    mem_stage_ext_if.slave bus
);
    if (DATA_W != 32) begin : g_bad_width
        $error("mem_stage_ext: DATA_W must be 32");
    end
    if (MEM_LATENCY < 0 || MEM_LATENCY > 7) begin : g_bad_latency
        $error("mem_stage_ext: MEM_LATENCY must be 0..7");
    end

    localparam logic [2:0] LAT_M1 = 3'(MEM_LATENCY == 0 ? 0 : MEM_LATENCY - 1);

    state_t            state;
    logic [2:0]        cnt;
    logic [1:0]        lo;
    logic              mem_op, bad, acc;
    logic [3:0]        be;
    logic [DATA_W-1:0] wlanes, rword, sh_w, load, rd;

    assign lo     = bus.address[1:0];
    assign mem_op = bus.in_valid & (bus.memread | bus.memwrite);
    assign bad    = mem_op & misaligned(bus.size, lo);
    assign acc    = mem_op & ~bad;
    // Misaligned accesses never wait; the final wait cycle (cnt==0) already drops stall
    assign bus.stall = state == IDLE ? (acc && MEM_LATENCY != 0) : cnt != 3'd0;
    assign bus.PCSrc = bus.in_valid & bus.branch & (bus.zero ^ bus.branch_ne);

    assign wlanes = bus.size == SZ_BYTE ? {4{bus.write_data[7:0]}} :
                    bus.size == SZ_HALF ? {2{bus.write_data[15:0]}} : bus.write_data;
    assign be     = (acc && bus.memwrite && !bus.stall && !reset) ? lane_en(bus.size, lo) : 4'b0000;

    byte_lane_mem #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_mem (
        .clk   (clk),
        .be    (be),
        .addr  (bus.address[DEPTH_LOG2+1:2]),
        .wdata (wlanes),
        .rdata (rword)
    );

    assign sh_w = rword >> {lo, 3'b000};
    assign load = bus.size == SZ_BYTE ? {{(DATA_W-8){bus.sign_ext & sh_w[7]}}, sh_w[7:0]} :
                  bus.size == SZ_HALF ? {{(DATA_W-16){bus.sign_ext & sh_w[15]}}, sh_w[15:0]} : rword;
    assign rd   = (acc && bus.memread) ? load : '0;

    // Wait-state FSM: IDLE loads the counter on a stalled accept, WAIT counts down to 0
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else if (state == IDLE) begin
            if (bus.stall) begin
                state <= WAIT;
                cnt   <= LAT_M1;
            end
        end else if (cnt == 3'd0) begin
            state <= IDLE;
        end else begin
            cnt <= cnt - 3'd1;
        end
    end

    // MEM/WB latch captures only when not stalled; invalid slots become all-zero bubbles
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.mem_valid      <= 1'b0;
            bus.mem_control_wb <= 2'b00;
            bus.mem_read_data  <= '0;
            bus.mem_ALU_result <= '0;
            bus.mem_Write_reg  <= 5'd0;
            bus.mem_misalign   <= 1'b0;
        end else if (!bus.stall) begin
            bus.mem_valid      <= bus.in_valid;
            bus.mem_control_wb <= bus.in_valid ? bus.control_wb : 2'b00;
            bus.mem_read_data  <= rd;
            bus.mem_ALU_result <= bus.in_valid ? bus.address : '0;
            bus.mem_Write_reg  <= bus.in_valid ? bus.write_reg : 5'd0;
            bus.mem_misalign   <= bad;
        end
    end
endmodule

// File: tb/tb_mem_stage_ext.sv
// tb_mem_stage_ext: directed checks of a zero-latency and a 3-wait-state MEM stage
module tb_mem_stage_ext;
    import mem_stage_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    int ns;
    logic pc_ok;

    always #5 clk = ~clk;

    mem_stage_ext_if #(.DATA_W(32)) b0 ();
    mem_stage_ext_if #(.DATA_W(32)) b3 ();

    mem_stage_ext #(.DATA_W(32), .DEPTH_LOG2(4), .MEM_LATENCY(0)) u0 (.clk(clk), .reset(reset), .bus(b0.slave));
    mem_stage_ext #(.DATA_W(32), .DEPTH_LOG2(4), .MEM_LATENCY(3)) u3 (.clk(clk), .reset(reset), .bus(b3.slave));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // One instruction into the zero-latency stage; outputs are valid on return
    task automatic op0(input logic rd, input logic wr, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        b0.in_valid = 1'b1; b0.memread = rd; b0.memwrite = wr; b0.size = sz; b0.sign_ext = sx;
        b0.address = a; b0.write_data = wd; b0.write_reg = 5'd9; b0.control_wb = 2'b11;
        #1 chk("stall_lat0", b0.stall, 0);
        @(posedge clk); #1;
    endtask

    // One instruction into the 3-wait-state stage; counts stall cycles and watches PCSrc
    task automatic op3(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd, output int n, output logic pc_stable);
        @(negedge clk);
        b3.in_valid = 1'b1; b3.memread = rd; b3.memwrite = wr; b3.size = sz; b3.sign_ext = 1'b0;
        b3.address = a; b3.write_data = wd; b3.write_reg = 5'd4; b3.control_wb = 2'b01;
        b3.branch = 1'b1; b3.branch_ne = 1'b1; b3.zero = 1'b0;
        n = 0; pc_stable = 1'b1;
        #1;
        while (b3.stall && n < 20) begin
            if (b3.PCSrc !== 1'b1) pc_stable = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        if (b3.PCSrc !== 1'b1) pc_stable = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        {b0.in_valid, b0.memread, b0.memwrite, b0.sign_ext, b0.branch, b0.branch_ne, b0.zero} = '0;
        {b0.size, b0.control_wb, b0.write_reg, b0.address, b0.write_data} = '0;
        {b3.in_valid, b3.memread, b3.memwrite, b3.sign_ext, b3.branch, b3.branch_ne, b3.zero} = '0;
        {b3.size, b3.control_wb, b3.write_reg, b3.address, b3.write_data} = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", b0.mem_valid, 0);
        chk("rst_rdata", b0.mem_read_data, 0);
        chk("rst_stall3", b3.stall, 0);
        chk("rst_valid3", b3.mem_valid, 0);
        @(negedge clk) reset = 1'b0;

        op0(0, 1, SZ_WORD, 0, 32'h10, 32'hDEADBEEF);
        chk("sw_valid", b0.mem_valid, 1);
        chk("sw_alu", b0.mem_ALU_result, 32'h10);
        chk("sw_rdata", b0.mem_read_data, 0);
        op0(1, 0, SZ_WORD, 0, 32'h10, 0);
        chk("lw_data", b0.mem_read_data, 32'hDEADBEEF);
        chk("lw_wreg", b0.mem_Write_reg, 9);
        chk("lw_cwb", b0.mem_control_wb, 3);

        op0(0, 1, SZ_WORD, 0, 32'h20, 32'h80FF7F01);
        op0(1, 0, SZ_BYTE, 1, 32'h22, 0);
        chk("lb_22", b0.mem_read_data, 32'hFFFFFFFF);
        op0(1, 0, SZ_BYTE, 0, 32'h23, 0);
        chk("lbu_23", b0.mem_read_data, 32'h00000080);
        op0(1, 0, SZ_HALF, 1, 32'h22, 0);
        chk("lh_22", b0.mem_read_data, 32'hFFFF80FF);
        op0(1, 0, SZ_HALF, 0, 32'h20, 0);
        chk("lhu_20", b0.mem_read_data, 32'h00007F01);
        op0(1, 0, SZ_BYTE, 1, 32'h21, 0);
        chk("lb_21", b0.mem_read_data, 32'h0000007F);

        op0(0, 1, SZ_HALF, 0, 32'h21, 32'h1234);
        chk("sh_mis_flag", b0.mem_misalign, 1);
        chk("sh_mis_rdata", b0.mem_read_data, 0);
        op0(1, 0, SZ_WORD, 0, 32'h20, 0);
        chk("mis_unchanged", b0.mem_read_data, 32'h80FF7F01);
        chk("mis_clear", b0.mem_misalign, 0);

        op0(0, 1, SZ_BYTE, 0, 32'h13, 32'h000000AB);
        op0(0, 1, SZ_HALF, 0, 32'h10, 32'h0000CAFE);
        op0(1, 0, SZ_WORD, 0, 32'h10, 0);
        chk("sb_sh_merge", b0.mem_read_data, 32'hABADCAFE);

        op0(1, 1, SZ_WORD, 0, 32'h10, 32'h11111111);
        chk("rdwr_old", b0.mem_read_data, 32'hABADCAFE);
        op0(1, 0, SZ_WORD, 0, 32'h10, 0);
        chk("rdwr_new", b0.mem_read_data, 32'h11111111);

        op0(0, 1, SZ_WORD, 0, 32'h1050, 32'h22222222);
        chk("wrap_alu", b0.mem_ALU_result, 32'h1050);
        op0(1, 0, SZ_WORD, 0, 32'h10, 0);
        chk("wrap_data", b0.mem_read_data, 32'h22222222);

        op0(0, 0, SZ_RSVD, 0, 32'h1234, 0);
        chk("nonmem_alu", b0.mem_ALU_result, 32'h1234);
        chk("nonmem_rdata", b0.mem_read_data, 0);
        chk("nonmem_mis", b0.mem_misalign, 0);

        @(negedge clk);
        b0.in_valid = 1'b0; b0.memread = 1'b1; b0.address = 32'h44;
        @(posedge clk); #1;
        chk("bubble_valid", b0.mem_valid, 0);
        chk("bubble_cwb", b0.mem_control_wb, 0);
        chk("bubble_alu", b0.mem_ALU_result, 0);
        chk("bubble_wreg", b0.mem_Write_reg, 0);

        @(negedge clk);
        b0.in_valid = 1'b1; b0.memread = 1'b0; b0.memwrite = 1'b0;
        b0.branch = 1'b1; b0.branch_ne = 1'b1; b0.zero = 1'b0;
        #1 chk("bne_taken", b0.PCSrc, 1);
        b0.zero = 1'b1;
        #1 chk("bne_not_taken", b0.PCSrc, 0);
        b0.in_valid = 1'b0; b0.branch = 1'b0;

        op3(0, 1, SZ_WORD, 32'h8, 32'h12345678, ns, pc_ok);
        chk("lat3_sw_stalls", ns, 3);
        chk("lat3_sw_alu", b3.mem_ALU_result, 32'h8);
        op3(1, 0, SZ_WORD, 32'h8, 0, ns, pc_ok);
        chk("lat3_lw_stalls", ns, 3);
        chk("lat3_pc_held", pc_ok, 1);
        chk("lat3_lw_data", b3.mem_read_data, 32'h12345678);
        @(negedge clk);
        b3.memread = 1'b0; b3.address = 32'h77;
        #1 chk("lat3_next_nostall", b3.stall, 0);
        @(posedge clk); #1;
        chk("lat3_next_alu", b3.mem_ALU_result, 32'h77);

        op3(1, 0, SZ_WORD, 32'h9, 0, ns, pc_ok);
        chk("lat3_mis_stalls", ns, 0);
        chk("lat3_mis_flag", b3.mem_misalign, 1);

        @(negedge clk);
        b3.memread = 1'b0; b3.memwrite = 1'b1; b3.address = 32'h8; b3.write_data = 32'hFFFFFFFF;
        #1 chk("abort_stall_T", b3.stall, 1);
        @(negedge clk);
        @(negedge clk);
        chk("abort_stall_w2", b3.stall, 1);
        reset = 1'b1; b3.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("abort_stall", b3.stall, 0);
        chk("abort_valid", b3.mem_valid, 0);
        chk("abort_alu", b3.mem_ALU_result, 0);
        chk("abort_mis", b3.mem_misalign, 0);
        @(negedge clk) reset = 1'b0;
        op3(1, 0, SZ_WORD, 32'h8, 0, ns, pc_ok);
        chk("abort_unchanged", b3.mem_read_data, 32'h12345678);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
